// File: rtl/ptw_multi.sv
// Multi-requestor Sv39/Sv48 page-table walker.
// Round-robin arbitration among NUM_REQ requestors, one walk at a time, at most one
// memory access outstanding. Performs the A/D writeback when a leaf needs it.
module ptw_multi #(
  parameter int NUM_REQ = 2,
  parameter int LEVELS  = 3,
  localparam int VPN_BITS = 9 * LEVELS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              priv,
  input  logic                    sum,
  input  logic [63:0]             satp,
  input  logic                    flush,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [64*NUM_REQ-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]      req_is_execute,
  input  logic [NUM_REQ-1:0]      req_is_store,
  output logic [NUM_REQ-1:0]      resp_valid,
  output logic [63:0]             resp_pte,
  output logic [VPN_BITS-1:0]     resp_tag,
  output logic [1:0]              resp_level,
  output logic                    resp_fault,
  output logic [63:0]             dm_req_addr,
  output logic [63:0]             dm_req_wdata,
  output logic [7:0]              dm_req_wmask,
  output logic                    dm_req_wen,
  output logic                    dm_req_valid,
  input  logic                    dm_req_ready,
  input  logic                    dm_resp_valid,
  input  logic [63:0]             dm_resp_rdata
);

  localparam int SLOT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [1:0] LVL_TOP = 2'(LEVELS - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_REQ  = 3'd1;
  localparam logic [2:0] RD_WAIT = 3'd2;
  localparam logic [2:0] WB_REQ  = 3'd3;
  localparam logic [2:0] WB_WAIT = 3'd4;
  localparam logic [2:0] DRAIN   = 3'd5;
  localparam logic [2:0] RESP    = 3'd6;

  logic [2:0]          state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [SLOT_W-1:0]   last_grant_q, last_grant_d;
  logic [63:0]         va_q, va_d;
  logic                exec_q, exec_d;
  logic                store_q, store_d;
  logic [1:0]          level_q, level_d;
  logic [63:0]         addr_q, addr_d;
  logic [63:0]         wdata_q, wdata_d;
  logic                wen_q, wen_d;
  logic [63:0]         rpte_q, rpte_d;
  logic [VPN_BITS-1:0] rtag_q, rtag_d;
  logic [1:0]          rlevel_q, rlevel_d;
  logic                rfault_q, rfault_d;

  logic                gnt_found;
  logic [SLOT_W-1:0]   gnt_slot;
  int                  idx;
  logic [NUM_REQ-1:0]  vld_rot;
  logic [63:0]         gnt_va;

  logic [63:0] pte;
  logic        misalign, perm_fail, priv_fail, need_wb;
  logic        unused_satp;

  assign unused_satp = ^satp[63:44];

  function automatic logic [8:0] vpn_idx(input logic [63:0] va, input logic [1:0] lvl);
    logic [63:0] sh;
    sh = va >> (12 + 9 * int'(lvl));
    return sh[8:0];
  endfunction

  // Round-robin pick: first valid slot after the last grant.
  always_comb begin
    gnt_found = 1'b0;
    gnt_slot  = '0;
    idx       = 0;
    vld_rot   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx     = (int'(last_grant_q) + k) % NUM_REQ;
      vld_rot = req_valid >> idx;
      if (!gnt_found && vld_rot[0]) begin
        gnt_found = 1'b1;
        gnt_slot  = SLOT_W'(idx);
      end
    end
    gnt_va = 64'(req_addr >> (64 * int'(gnt_slot)));
  end

  // Leaf PTE checks against the latched access and current level.
  always_comb begin
    pte      = dm_resp_rdata;
    misalign = 1'b0;
    for (int i = 0; i < 9 * (LEVELS - 1); i++) begin
      if (i < 9 * int'(level_q) && pte[10+i]) misalign = 1'b1;
    end
    perm_fail = exec_q ? !pte[3] : (store_q ? !pte[2] : !pte[1]);
    priv_fail = (priv == 2'd0) ? !pte[4] : (pte[4] && (!sum || exec_q));
    need_wb   = !pte[6] || (store_q && !pte[7]);
  end

  // Walk FSM next-state and datapath.
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    last_grant_d = last_grant_q;
    va_d         = va_q;
    exec_d       = exec_q;
    store_d      = store_q;
    level_d      = level_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wen_d        = wen_q;
    rpte_d       = rpte_q;
    rtag_d       = rtag_q;
    rlevel_d     = rlevel_q;
    rfault_d     = rfault_q;
    unique case (state_q)
      IDLE: begin
        if (!flush && gnt_found) begin
          slot_d       = gnt_slot;
          last_grant_d = gnt_slot;
          va_d         = gnt_va;
          exec_d       = req_is_execute[gnt_slot];
          store_d      = req_is_store[gnt_slot];
          level_d      = LVL_TOP;
          addr_d       = {8'b0, satp[43:0], vpn_idx(gnt_va, LVL_TOP), 3'b0};
          wen_d        = 1'b0;
          state_d      = RD_REQ;
        end
      end
      RD_REQ: begin
        if (flush) state_d = IDLE;
        else if (dm_req_ready) state_d = RD_WAIT;
      end
      WB_REQ: begin
        if (flush) state_d = IDLE;
        else if (dm_req_ready) state_d = WB_WAIT;
      end
      RD_WAIT: begin
        if (dm_resp_valid) begin
          if (flush) begin
            state_d = IDLE;
          end else begin
            // Default: finish with the raw PTE as a fault; overridden below.
            rpte_d   = pte;
            rtag_d   = VPN_BITS'(va_q >> 12);
            rlevel_d = level_q;
            rfault_d = 1'b1;
            state_d  = RESP;
            if (!pte[0] || (!pte[1] && pte[2])) begin
              rfault_d = 1'b1;
            end else if (!pte[1] && !pte[3]) begin
              if (level_q != 2'd0 && !pte[6] && !pte[7] && !pte[4]) begin
                level_d  = level_q - 2'd1;
                addr_d   = {8'b0, pte[53:10], vpn_idx(va_q, level_q - 2'd1), 3'b0};
                rfault_d = rfault_q;
                state_d  = RD_REQ;
              end
            end else if (misalign || perm_fail || priv_fail) begin
              rfault_d = 1'b1;
            end else if (need_wb) begin
              wdata_d  = pte | 64'h40 | (store_q ? 64'h80 : 64'h0);
              wen_d    = 1'b1;
              rfault_d = rfault_q;
              state_d  = WB_REQ;
            end else begin
              rfault_d = 1'b0;
            end
          end
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      WB_WAIT: begin
        if (dm_resp_valid) begin
          if (flush) begin
            state_d = IDLE;
          end else begin
            rpte_d   = wdata_q;
            rtag_d   = VPN_BITS'(va_q >> 12);
            rlevel_d = level_q;
            rfault_d = 1'b0;
            state_d  = RESP;
          end
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (dm_resp_valid) state_d = IDLE;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      slot_q       <= '0;
      last_grant_q <= SLOT_W'(NUM_REQ - 1);
      va_q         <= '0;
      exec_q       <= 1'b0;
      store_q      <= 1'b0;
      level_q      <= LVL_TOP;
      addr_q       <= '0;
      wdata_q      <= '0;
      wen_q        <= 1'b0;
      rpte_q       <= '0;
      rtag_q       <= '0;
      rlevel_q     <= '0;
      rfault_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      last_grant_q <= last_grant_d;
      va_q         <= va_d;
      exec_q       <= exec_d;
      store_q      <= store_d;
      level_q      <= level_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wen_q        <= wen_d;
      rpte_q       <= rpte_d;
      rtag_q       <= rtag_d;
      rlevel_q     <= rlevel_d;
      rfault_q     <= rfault_d;
    end
  end

  // Handshake and result outputs.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && !flush && !rst && gnt_found) req_ready = NUM_REQ'(1) << gnt_slot;
    resp_valid = (state_q == RESP) ? (NUM_REQ'(1) << slot_q) : '0;
    dm_req_valid = (state_q == RD_REQ || state_q == WB_REQ) && !flush;
  end

  assign dm_req_addr  = addr_q;
  assign dm_req_wdata = wdata_q;
  assign dm_req_wen   = wen_q;
  assign dm_req_wmask = 8'hff;
  assign resp_pte     = rpte_q;
  assign resp_tag     = rtag_q;
  assign resp_level   = rlevel_q;
  assign resp_fault   = rfault_q;

endmodule

// File: tb/tb_ptw_multi.sv
// Directed bench for ptw_multi: small page table in a behavioural memory,
// hand-computed expected responses, arbitration, flush and reset scenarios.
module tb_ptw_multi;
  localparam int NUM_REQ = 2;
  localparam int LEVELS  = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   priv;
  logic         sum;
  logic [63:0]  satp;
  logic         flush;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [127:0] req_addr;
  logic [1:0]   req_is_execute;
  logic [1:0]   req_is_store;
  logic [1:0]   resp_valid;
  logic [63:0]  resp_pte;
  logic [26:0]  resp_tag;
  logic [1:0]   resp_level;
  logic         resp_fault;
  logic [63:0]  dm_req_addr;
  logic [63:0]  dm_req_wdata;
  logic [7:0]   dm_req_wmask;
  logic         dm_req_wen;
  logic         dm_req_valid;
  logic         dm_req_ready;
  logic         dm_resp_valid = 1'b0;
  logic [63:0]  dm_resp_rdata = 64'h0;

  ptw_multi #(.NUM_REQ(NUM_REQ), .LEVELS(LEVELS)) dut (
    .clk(clk), .rst(rst), .priv(priv), .sum(sum), .satp(satp), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_is_execute(req_is_execute), .req_is_store(req_is_store),
    .resp_valid(resp_valid), .resp_pte(resp_pte), .resp_tag(resp_tag),
    .resp_level(resp_level), .resp_fault(resp_fault),
    .dm_req_addr(dm_req_addr), .dm_req_wdata(dm_req_wdata), .dm_req_wmask(dm_req_wmask),
    .dm_req_wen(dm_req_wen), .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready),
    .dm_resp_valid(dm_resp_valid), .dm_resp_rdata(dm_resp_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: reads return the table contents; writes are logged only.
  logic [63:0] mem [logic [63:0]];
  int          resp_delay = 0;
  logic        hold_wb = 1'b0;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [63:0] pend_data = 64'h0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [63:0] last_wr_addr = 64'h0;
  logic [63:0] last_wr_data = 64'h0;

  assign dm_req_ready = !(hold_wb && dm_req_wen);

  // Accept a request, answer resp_delay+1 cycles later.
  always @(posedge clk) begin
    dm_resp_valid <= 1'b0;
    if (pend) begin
      if (cnt == 0) begin
        dm_resp_valid <= 1'b1;
        dm_resp_rdata <= pend_data;
        pend          <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end
    if (dm_req_valid && dm_req_ready) begin
      pend      <= 1'b1;
      cnt       <= resp_delay;
      pend_data <= mem.exists(dm_req_addr) ? mem[dm_req_addr] : 64'h0;
      if (dm_req_wen) begin
        wr_cnt       <= wr_cnt + 1;
        last_wr_addr <= dm_req_addr;
        last_wr_data <= dm_req_wdata;
      end else begin
        rd_cnt <= rd_cnt + 1;
      end
    end
  end

  // Response / grant monitor, sampled mid-cycle.
  int          resp_cnt = 0;
  logic [1:0]  r_valid = 2'b0;
  logic [63:0] r_pte = 64'h0;
  logic [26:0] r_tag = 27'h0;
  logic [1:0]  r_level = 2'b0;
  logic        r_fault = 1'b0;
  int          gnt_q[$];

  always @(negedge clk) begin
    if (|resp_valid) begin
      resp_cnt <= resp_cnt + 1;
      r_valid  <= resp_valid;
      r_pte    <= resp_pte;
      r_tag    <= resp_tag;
      r_level  <= resp_level;
      r_fault  <= resp_fault;
    end
    if (|(req_valid & req_ready)) gnt_q.push_back(req_ready[1] ? 1 : 0);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_resp(input int start, input string tag);
    int n = 0;
    while (resp_cnt == start && n < 300) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_resp_seen"}, 64'(resp_cnt != start), 64'd1);
  endtask

  task automatic wait_grant(input int slot, input string tag);
    int n = 0;
    while (!req_ready[slot] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_granted"}, 64'(req_ready[slot]), 64'd1);
    @(posedge clk);
    #1 req_valid[slot] = 1'b0;
  endtask

  task automatic do_walk(input int slot, input logic [63:0] va, input logic ex, input logic st,
                         input string tag);
    int start;
    @(negedge clk);
    req_addr[64*slot +: 64] = va;
    req_is_execute[slot]    = ex;
    req_is_store[slot]      = st;
    req_valid[slot]         = 1'b1;
    start                   = resp_cnt;
    #1;
    wait_grant(slot, tag);
    wait_resp(start, tag);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, w0, start, g0, n;
    rst = 1'b1; flush = 1'b0; req_valid = 2'b11; priv = 2'd1; sum = 1'b0;
    satp = 64'h100; req_addr = '0; req_is_execute = '0; req_is_store = '0;

    // Root at 0x100000, L1 table 0x101000, L0 table 0x102000.
    mem[64'h100000] = 64'h40401;   // -> 0x101000
    mem[64'h101010] = 64'h40801;   // VA 0x402000 L1 -> 0x102000
    mem[64'h101018] = 64'h443;     // VA 0x600000: misaligned superpage
    mem[64'h101020] = 64'h80043;   // VA 0x800000: aligned 2 MiB leaf
    mem[64'h102010] = 64'h155443;  // VA 0x402000 leaf: V R A
    mem[64'h102018] = 64'h155847;  // VA 0x403000 leaf: V R W A, D clear

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'h0);
    check("rst_resp_valid", 64'(resp_valid), 64'h0);
    check("rst_dm_valid", 64'(dm_req_valid), 64'h0);
    check("rst_dm_wen", 64'(dm_req_wen), 64'h0);
    check("rst_fault", 64'(resp_fault), 64'h0);
    check("wmask", 64'(dm_req_wmask), 64'hff);
    req_valid = 2'b00;
    rst = 1'b0;

    // Three-level load walk.
    r0 = rd_cnt; w0 = wr_cnt;
    do_walk(0, 64'h0040_2000, 1'b0, 1'b0, "t1");
    check("t1_reads", 64'(rd_cnt - r0), 64'd3);
    check("t1_writes", 64'(wr_cnt - w0), 64'd0);
    check("t1_valid", 64'(r_valid), 64'h1);
    check("t1_level", 64'(r_level), 64'd0);
    check("t1_fault", 64'(r_fault), 64'd0);
    check("t1_tag", 64'(r_tag), 64'h402);
    check("t1_pte", r_pte, 64'h155443);
    repeat (2) @(negedge clk);
    check("t1_hold_pte", resp_pte, 64'h155443);

    // Superpage alignment.
    do_walk(0, 64'h0060_0000, 1'b0, 1'b0, "t2a");
    check("t2a_fault", 64'(r_fault), 64'd1);
    check("t2a_level", 64'(r_level), 64'd1);
    check("t2a_pte", r_pte, 64'h443);
    do_walk(1, 64'h0080_0000, 1'b0, 1'b0, "t2b");
    check("t2b_valid", 64'(r_valid), 64'h2);
    check("t2b_fault", 64'(r_fault), 64'd0);
    check("t2b_level", 64'(r_level), 64'd1);
    check("t2b_tag", 64'(r_tag), 64'h800);
    check("t2b_pte", r_pte, 64'h80043);

    // Store to a clean page sets D via one writeback.
    w0 = wr_cnt;
    do_walk(0, 64'h0040_3000, 1'b0, 1'b1, "t3");
    check("t3_writes", 64'(wr_cnt - w0), 64'd1);
    check("t3_wr_addr", last_wr_addr, 64'h102018);
    check("t3_wr_data", last_wr_data, 64'h1558c7);
    check("t3_pte", r_pte, 64'h1558c7);
    check("t3_fault", 64'(r_fault), 64'd0);
    req_is_store[0] = 1'b0;

    // Execute on a non-executable leaf.
    do_walk(1, 64'h0040_2000, 1'b1, 1'b0, "t3x");
    check("t3x_fault", 64'(r_fault), 64'd1);
    req_is_execute[1] = 1'b0;

    // Both requestors held valid for four walks after reset.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    g0 = gnt_q.size();
    start = resp_cnt;
    req_addr[63:0] = 64'h0040_2000;
    req_addr[127:64] = 64'h0080_0000;
    req_valid = 2'b11;
    n = 0;
    while (resp_cnt - start < 4 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1 req_valid = 2'b00;
    repeat (4) @(negedge clk);
    check("t4_resps", 64'(resp_cnt - start), 64'd4);
    check("t4_grants", 64'(gnt_q.size() - g0), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (g0 + i < gnt_q.size()) check($sformatf("t4_grant%0d", i), 64'(gnt_q[g0+i]), 64'(i % 2));
    end

    // Flush during RD_WAIT; then a user-mode walk to a supervisor page.
    priv = 2'd0;
    resp_delay = 3;
    start = resp_cnt;
    @(negedge clk);
    req_addr[63:0] = 64'h0040_2000;
    req_valid[0] = 1'b1;
    #1;
    wait_grant(0, "t5a");
    @(negedge clk);
    n = 0;
    while (!(dm_req_valid && dm_req_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    req_valid[0] = 1'b1;
    check("t5_drain_ready", 64'(req_ready), 64'h0);
    n = 0;
    while (!dm_resp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t5_drain_resp_seen", 64'(dm_resp_valid), 64'd1);
    check("t5_drain_ready2", 64'(req_ready), 64'h0);
    @(negedge clk);
    check("t5_idle_ready", 64'(req_ready), 64'h1);
    check("t5_no_resp", 64'(resp_cnt), 64'(start));
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    wait_resp(start, "t5b");
    check("t5b_fault", 64'(r_fault), 64'd1);
    check("t5b_level", 64'(r_level), 64'd0);
    check("t5b_pte", r_pte, 64'h155443);
    priv = 2'd1;
    resp_delay = 0;

    // Reset while the writeback request is stalled.
    repeat (2) @(negedge clk);
    hold_wb = 1'b1;
    w0 = wr_cnt;
    start = resp_cnt;
    req_addr[63:0] = 64'h0040_3000;
    req_is_store[0] = 1'b1;
    req_valid[0] = 1'b1;
    #1;
    wait_grant(0, "t6");
    n = 0;
    while (!(dm_req_valid && dm_req_wen) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t6_in_wb", 64'(dm_req_valid && dm_req_wen), 64'd1);
    check("t6_wb_data", dm_req_wdata, 64'h1558c7);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_dm_valid", 64'(dm_req_valid), 64'd0);
    check("t6_rst_dm_wen", 64'(dm_req_wen), 64'd0);
    rst = 1'b0;
    hold_wb = 1'b0;
    req_is_store[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_no_resp", 64'(resp_cnt), 64'(start));
    check("t6_no_write", 64'(wr_cnt), 64'(w0));
    do_walk(1, 64'h0080_0000, 1'b0, 1'b0, "t6b");
    check("t6b_valid", 64'(r_valid), 64'h2);
    check("t6b_fault", 64'(r_fault), 64'd0);
    check("t6b_pte", r_pte, 64'h80043);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ptw_multi.md
PTW_MULTI -- requirements
Module: ptw_multi

Interface
REQ-001 Parameter NUM_REQ, 2, number of requestors (1..4).
REQ-002 Parameter LEVELS, 3, page-table levels (3 = Sv39, 4 = Sv48); VPN_BITS = 9*LEVELS.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 rst  in  1  reset rst, synchronous, active-high.
REQ-005 priv  in  2  effective privilege (0 = U, 1 = S; 3 treated as S).
REQ-006 sum  in  1  mstatus.SUM.
REQ-007 satp  in  64  root PPN in [43:0].
REQ-008 flush  in  1  sfence/abort; kills the current walk.
REQ-009 req_valid / req_ready  in / out  NUM_REQ  per-requestor handshake.
REQ-010 req_addr  in  64*NUM_REQ  virtual address; slot i at [64*i +: 64].
REQ-011 req_is_execute, req_is_store  in  NUM_REQ  access type per slot.
REQ-012 resp_valid  out  NUM_REQ  one-hot, one-cycle result pulse to the owning requestor.
REQ-013 resp_pte  out  64  final PTE (post A/D update).
REQ-014 resp_tag  out  VPN_BITS  VPN of the walked address.
REQ-015 resp_level  out  2  leaf level (0 = 4 KiB page, 1 = 2 MiB, ...).
REQ-016 resp_fault  out  1  page fault.
REQ-017 dm_req_addr, dm_req_wdata  out  64  memory request.
REQ-018 dm_req_wmask  out  8  constant 8'hff.
REQ-019 dm_req_wen, dm_req_valid  out  1.
REQ-020 dm_req_ready, dm_resp_valid  in  1.
REQ-021 dm_resp_rdata  in  64.

Function
REQ-022 States: IDLE, RD_REQ, RD_WAIT, WB_REQ, WB_WAIT, DRAIN, RESP; at most one memory access outstanding.
REQ-023 IDLE without flush: round-robin grant starting at slot (last_grant+1) mod NUM_REQ; req_ready is combinational and one-hot, high only for the granted valid slot, and low outside IDLE or while flush=1.
REQ-024 On grant: latch addr, type and slot; level = LEVELS-1; dm_req_addr = {8'b0, satp[43:0], VA[12+9*level +: 9], 3'b0}; wen = 0; next state RD_REQ; last_grant <= slot.
REQ-025 RD_REQ/WB_REQ: dm_req_valid = 1, address/wdata/wen stable; on dm_req_ready go to RD_WAIT/WB_WAIT.
REQ-026 RD_WAIT on dm_resp_valid, first matching rule applies:
 - fault if V = 0 or (R = 0 and W = 1);
 - non-leaf (R = X = 0): fault if level = 0 or any of A/D/U is set; otherwise level -= 1, next address {8'b0, pte[53:10], VA index for the new level, 3'b0}, go to RD_REQ;
 - leaf: fault if pte[10 +: 9*level] != 0 (misaligned superpage);
 - leaf: fault if the access bit is clear (execute needs X, store needs W, load needs R);
 - leaf: fault if (priv = U and U = 0) or (priv = S and U = 1 and (sum = 0 or execute));
 - leaf OK with A = 0 or (store and D = 0): wdata = pte | A | (store ? D : 0), wen = 1, same address, go to WB_REQ;
 - otherwise capture the PTE and go to RESP.
REQ-027 WB_WAIT on dm_resp_valid: capture wdata as the result PTE, go to RESP.
REQ-028 RESP lasts one cycle: resp_valid[slot] = 1 with pte/tag/level/fault; next state IDLE. On fault, resp_pte = raw PTE read.
REQ-029 resp_* data outputs hold their values until the next RESP.
REQ-030 Latency with a 1-cycle-ready, next-cycle-response memory and no writeback: 3*(LEVELS-level_leaf)+2 cycles from grant to resp_valid.
REQ-031 flush in RD_REQ or WB_REQ before dm_req_ready: drop dm_req_valid, go to IDLE, no response.
REQ-032 flush in RD_WAIT/WB_WAIT: go to DRAIN; discard dm_resp_valid (a writeback still completes in memory), then go to IDLE; no response.
REQ-033 flush in the same cycle as dm_resp_valid in a WAIT state: go directly to IDLE, no response.
REQ-034 flush in RESP: the response still issues.
REQ-035 A requestor may hold req_valid across walks; after a RESP the grant pointer guarantees fairness, with no slot starved beyond NUM_REQ-1 walks.

Reset
REQ-036 rst: state IDLE, last_grant = NUM_REQ-1, dm_req_valid = 0, dm_req_wen = 0, resp_valid = 0, req_ready = 0, resp_fault = 0, level = LEVELS-1; rst overrides flush and all handshakes, including mid-walk.

Verification
REQ-037 LEVELS = 3, slot 0 load VA 0x0040_2000, all PTEs V/A/R set at level 0 -> three reads, resp_valid = 2'b01, level 0, fault 0, tag = 0x00402.
REQ-038 Level-1 leaf PTE with pte[18:10] = 0x001 -> resp_fault = 1, level 1 (misaligned); the leaf with PPN[0] = 0 -> fault 0, level 1.
REQ-039 Store to a leaf with A = 1, D = 0 -> one write with wdata[7] = 1 and wen = 1, then resp_pte[7] = 1, fault 0.
REQ-040 req_valid = 2'b11 held for 4 walks -> grants alternate 0, 1, 0, 1 after reset.
REQ-041 flush asserted in RD_WAIT -> DRAIN absorbs dm_resp_valid, no resp_valid, IDLE next cycle; priv = U with a U = 0 leaf -> fault 1.
REQ-042 rst asserted in WB_REQ -> dm_req_valid = 0 next cycle, no response, a new grant is accepted afterwards.
